vga_fb_scheduler: RTL and testbench

- Display-timing controller that also owns a single-port frame-buffer RAM.
- Generates hsyn/vsyn/de from one clock domain; the horizontal and vertical counters share that clock, with no clock derived from hsyn.
- Schedules RAM reads for pixel refresh and grants host writes only in cycles when the display does not need the RAM.
- Sits between the host write path and the VGA pins.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_timing_core.sv | 116 +++++++++++
 rtl/vga_fb_scheduler.sv | 175 +++++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared definitions for the VGA frame-buffer scheduler.
//                Default display timing, frame-buffer depth, the RAM request
//                record used by the arbiter and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    // Default 800x500 timing with a 640x480 active window
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 160;
    localparam int DEF_H_ACT_START = 160;
    localparam int DEF_H_ACT_LEN   = 640;
    localparam int DEF_V_TOTAL     = 500;
    localparam int DEF_V_SYNC      = 20;
    localparam int DEF_V_ACT_START = 20;
    localparam int DEF_V_ACT_LEN   = 480;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 19;

    // Number of words the frame buffer holds for the default geometry
    localparam int FB_DEPTH = DEF_H_ACT_LEN * DEF_V_ACT_LEN;

    // One RAM access as seen on the single memory port
    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    // Bits needed for a counter running 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : vga_pkg

`default_nettype wire

// File: rtl/vga_timing_core.sv
// ============================================================================
//  Module      : vga_timing_core
//  Description : Horizontal/vertical raster counters with registered sync,
//                display-enable and frame-start decode, plus the
//                combinational display-read slot one pixel ahead of de.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                hsyn, vsyn      - active-low syncs (registered)
//                de              - display enable (registered)
//                frame_start     - pulse for the h=0,v=0 output cycle
//                disp_rd         - this cycle must read the frame buffer
//                first_rd        - this is the first read of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_LEN   = DEF_H_ACT_LEN,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_LEN   = DEF_V_ACT_LEN
) (
    input  logic clk,
    input  logic rst,
    output logic hsyn,
    output logic vsyn,
    output logic de,
    output logic frame_start,
    output logic disp_rd,
    output logic first_rd
);

    localparam int HW = cnt_width(H_TOTAL);
    localparam int VW = cnt_width(V_TOTAL);

    // Boundaries pre-sized to the counter widths
    localparam logic [HW-1:0] c_h_last      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_sync      = HW'(H_SYNC);
    localparam logic [HW-1:0] c_h_act_first = HW'(H_ACT_START);
    localparam logic [HW-1:0] c_h_act_last  = HW'(H_ACT_START + H_ACT_LEN - 1);
    localparam logic [HW-1:0] c_h_rd_first  = HW'(H_ACT_START - 1);
    localparam logic [HW-1:0] c_h_rd_last   = HW'(H_ACT_START + H_ACT_LEN - 2);
    localparam logic [VW-1:0] c_v_last      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_sync      = VW'(V_SYNC);
    localparam logic [VW-1:0] c_v_act_first = VW'(V_ACT_START);
    localparam logic [VW-1:0] c_v_act_last  = VW'(V_ACT_START + V_ACT_LEN - 1);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_hsyn;
    logic          r_vsyn;
    logic          r_de;
    logic          r_frame_start;

    logic w_h_wrap;
    logic w_v_act;
    logic w_h_act;
    logic w_h_rd;

    assign w_h_wrap = (r_h == c_h_last);
    assign w_v_act  = (r_v >= c_v_act_first) && (r_v <= c_v_act_last);
    assign w_h_act  = (r_h >= c_h_act_first) && (r_h <= c_h_act_last);
    assign w_h_rd   = (r_h >= c_h_rd_first)  && (r_h <= c_h_rd_last);

    // Both counters run on clk; v only steps in the cycle h wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            if (w_h_wrap) begin
                r_h <= '0;
                if (r_v == c_v_last) begin
                    r_v <= '0;
                end else begin
                    r_v <= r_v + VW'(1);
                end
            end else begin
                r_h <= r_h + HW'(1);
            end
        end
    end

    // Decode of counter cycle c appears on the pins at c+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsyn        <= 1'b0;
            r_vsyn        <= 1'b0;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsyn        <= (r_h >= c_h_sync);
            r_vsyn        <= (r_v >= c_v_sync);
            r_de          <= w_h_act && w_v_act;
            r_frame_start <= (r_h == '0) && (r_v == '0);
        end
    end

    assign hsyn        = r_hsyn;
    assign vsyn        = r_vsyn;
    assign de          = r_de;
    assign frame_start = r_frame_start;

    // Held counters during reset could decode as a read slot for some
    // geometries; masking keeps the RAM port quiet while reset is asserted.
    assign disp_rd  = !rst && w_v_act && w_h_rd;
    assign first_rd = !rst && (r_v == c_v_act_first) && (r_h == c_h_rd_first);

endmodule : vga_timing_core

`default_nettype wire

// File: rtl/vga_fb_scheduler.sv
// ============================================================================
//  Module      : vga_fb_scheduler
//  Description : VGA display-timing controller owning a single-port frame
//                buffer. Display refresh reads take absolute priority; host
//                writes are granted in every cycle the display leaves free.
//  Ports       : clk, greset                  - clock, async active-high reset
//                hsyn, vsyn, de, pix_out      - registered VGA outputs
//                frame_start                  - pulse at the h=0,v=0 output
//                mem_en/we/addr/wdata, mem_rdata - frame-buffer RAM port
//                host_req/addr/wdata          - held host write request
//                host_gnt                     - write issued this cycle
//                host_err                     - out-of-range write dropped
//                DATA_W/ADDR_W must equal the widths of vga_pkg::mem_req_t.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_LEN   = DEF_H_ACT_LEN,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_LEN   = DEF_V_ACT_LEN,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              greset,
    output logic              hsyn,
    output logic              vsyn,
    output logic              de,
    output logic [DATA_W-1:0] pix_out,
    output logic              frame_start,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_err
);

    // Frame-buffer depth for the configured geometry, one bit wider than
    // an address so a full 2^ADDR_W buffer still compares correctly.
    localparam logic [ADDR_W:0] c_fb_depth = (ADDR_W + 1)'(H_ACT_LEN * V_ACT_LEN);

    logic w_disp_rd;
    logic w_first_rd;

    vga_timing_core #(
        .H_TOTAL     (H_TOTAL),
        .H_SYNC      (H_SYNC),
        .H_ACT_START (H_ACT_START),
        .H_ACT_LEN   (H_ACT_LEN),
        .V_TOTAL     (V_TOTAL),
        .V_SYNC      (V_SYNC),
        .V_ACT_START (V_ACT_START),
        .V_ACT_LEN   (V_ACT_LEN)
    ) u_timing (
        .clk         (clk),
        .rst         (greset),
        .hsyn        (hsyn),
        .vsyn        (vsyn),
        .de          (de),
        .frame_start (frame_start),
        .disp_rd     (w_disp_rd),
        .first_rd    (w_first_rd)
    );

    // ------------------------------------------------------------------
    // Display read address
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    // The first read of each frame uses address 0 directly, so the frame
    // restarts cleanly whatever the counter was left at.
    assign w_rd_addr = w_first_rd ? '0 : r_rd_addr;

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_rd_addr <= '0;
        end else if (w_disp_rd) begin
            r_rd_addr <= w_rd_addr + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Arbiter: display first, host in any remaining cycle
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_wdata;
    logic              w_in_range;
    mem_req_t          w_req;

    assign w_in_range = ({1'b0, host_addr} < c_fb_depth);

    always_comb begin
        // Idle: no access, address/data keep their last driven value
        w_req.en    = 1'b0;
        w_req.we    = 1'b0;
        w_req.addr  = r_hold_addr;
        w_req.wdata = r_hold_wdata;
        host_gnt    = 1'b0;
        if (w_disp_rd) begin
            w_req.en   = 1'b1;
            w_req.addr = w_rd_addr;
        end else if (host_req && !greset) begin
            // Out-of-range writes are still granted (and retired) but
            // never reach the RAM array.
            host_gnt    = 1'b1;
            w_req.en    = 1'b1;
            w_req.we    = w_in_range;
            w_req.addr  = host_addr;
            w_req.wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else if (w_req.en) begin
            r_hold_addr  <= w_req.addr;
            r_hold_wdata <= w_req.wdata;
        end
    end

    assign mem_en    = w_req.en;
    assign mem_we    = w_req.we;
    assign mem_addr  = w_req.addr;
    assign mem_wdata = w_req.wdata;

    // ------------------------------------------------------------------
    // Error pulse and pixel register
    // ------------------------------------------------------------------
    logic              r_host_err;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_pix;

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_host_err <= 1'b0;
        end else begin
            r_host_err <= host_gnt && !w_in_range;
        end
    end

    // A read issued one cycle ahead of the pixel returns data in the
    // cycle whose decode produces de, so the one-cycle-delayed read flag
    // lines pix_out up with de and forces zero elsewhere.
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_rd_pend <= 1'b0;
            r_pix     <= '0;
        end else begin
            r_rd_pend <= w_disp_rd;
            r_pix     <= r_rd_pend ? mem_rdata : '0;
        end
    end

    assign host_err = r_host_err;
    assign pix_out  = r_pix;

endmodule : vga_fb_scheduler

`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
// ============================================================================
//  Module      : tb_vga_fb_scheduler
//  Description : Self-checking bench for vga_fb_scheduler on a reduced
//                40x20 raster with a 24x12 active window. A reference raster
//                model predicts sync/de/RAM-port behaviour each cycle and a
//                pixel queue holds the expected RAM words for pix_out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_scheduler;

    localparam int HT    = 40;
    localparam int HS    = 6;
    localparam int HAS   = 8;
    localparam int HAL   = 24;
    localparam int VT    = 20;
    localparam int VS    = 2;
    localparam int VAS   = 4;
    localparam int VAL   = 12;
    localparam int DW    = 8;
    localparam int AW    = 19;
    localparam int DEPTH = HAL * VAL;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          greset;
    logic          hsyn, vsyn, de, frame_start;
    logic [DW-1:0] pix_out;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_fb_scheduler #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_LEN(VAL),
        .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .greset(greset),
        .hsyn(hsyn), .vsyn(vsyn), .de(de), .pix_out(pix_out),
        .frame_start(frame_start),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_err(host_err)
    );

    // Synchronous single-port RAM, preloaded with addr[7:0]
    logic [7:0] ram [0:1023];
    bit         ram_ready;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i);
            ram_ready <= 1'b1;
            mem_rdata <= '0;
        end else begin
            if (mem_en && mem_we)  ram[mem_addr[9:0]] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    // ------------------------------------------------------------------
    // Reference raster model and pixel scoreboard
    // ------------------------------------------------------------------
    int         m_h, m_v;
    bit         e_hs, e_vs, e_de, e_fs;
    logic [7:0] pixq [$];

    function automatic bit f_rd(input int h, input int v);
        return (v >= VAS) && (v < VAS + VAL) && (h >= HAS - 1) && (h <= HAS + HAL - 2);
    endfunction

    function automatic bit f_de(input int h, input int v);
        return (v >= VAS) && (v < VAS + VAL) && (h >= HAS) && (h < HAS + HAL);
    endfunction

    always @(negedge clk) begin : mon
        int         a;
        logic [7:0] ep;
        if (greset) begin
            checks++;
            if ({hsyn, vsyn, de, frame_start, host_gnt, host_err, mem_en, mem_we} !== 8'h00 ||
                pix_out !== '0 || mem_addr !== '0) begin
                failures++;
                $display("FAIL mon_reset got sync/de/fs/gnt/err/en/we=%b pix=%h addr=%0d want all 0",
                         {hsyn, vsyn, de, frame_start, host_gnt, host_err, mem_en, mem_we}, pix_out, mem_addr);
            end
            m_h = 0; m_v = 0;
            e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0;
            pixq.delete();
        end else begin
            checks++;
            if ({hsyn, vsyn, de, frame_start} !== {e_hs, e_vs, e_de, e_fs}) begin
                failures++;
                $display("FAIL mon_decode h=%0d v=%0d got hs/vs/de/fs=%b want %b",
                         m_h, m_v, {hsyn, vsyn, de, frame_start}, {e_hs, e_vs, e_de, e_fs});
            end
            checks++;
            if (e_de) begin
                if (pixq.size() == 0) begin
                    failures++;
                    $display("FAIL mon_pixel got pix=%h want a queued pixel (queue empty)", pix_out);
                end else begin
                    ep = pixq.pop_front();
                    if (pix_out !== ep) begin
                        failures++;
                        $display("FAIL mon_pixel h=%0d v=%0d got pix=%h want %h", m_h, m_v, pix_out, ep);
                    end
                end
            end else if (pix_out !== '0) begin
                failures++;
                $display("FAIL mon_pix_blank h=%0d v=%0d got pix=%h want 00", m_h, m_v, pix_out);
            end
            checks++;
            if (f_rd(m_h, m_v)) begin
                a = (m_v - VAS) * HAL + (m_h + 1 - HAS);
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(a) || host_gnt !== 1'b0) begin
                    failures++;
                    $display("FAIL mon_disp_rd h=%0d v=%0d got en=%b we=%b addr=%0d gnt=%b want 1 0 %0d 0",
                             m_h, m_v, mem_en, mem_we, mem_addr, host_gnt, a);
                end
                pixq.push_back(ram[a]);
            end else if (host_req) begin
                if (host_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== (host_addr < AW'(DEPTH)) ||
                    mem_addr !== host_addr || mem_wdata !== host_wdata) begin
                    failures++;
                    $display("FAIL mon_grant h=%0d v=%0d got gnt=%b en=%b we=%b addr=%0d wd=%h want 1 1 %b %0d %h",
                             m_h, m_v, host_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                             host_addr < AW'(DEPTH), host_addr, host_wdata);
                end
            end else if (host_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL mon_idle h=%0d v=%0d got gnt=%b en=%b we=%b want 0 0 0",
                         m_h, m_v, host_gnt, mem_en, mem_we);
            end
            e_hs = (m_h >= HS);
            e_vs = (m_v >= VS);
            e_de = f_de(m_h, m_v);
            e_fs = (m_h == 0) && (m_v == 0);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    end

    // Returns one step after a posedge where the model sits at (h, v)
    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(m_h == h && m_v == v) && n < 2 * FRAME);
    endtask

    // ------------------------------------------------------------------
    // Scenario tasks
    // ------------------------------------------------------------------
    task automatic test_reset();
        greset = 1'b1; host_req = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({hsyn, vsyn, de, frame_start, mem_en, mem_we, host_gnt, host_err} !== 8'h00 ||
            pix_out !== '0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_state got %b pix=%h addr=%0d want zeros",
                     {hsyn, vsyn, de, frame_start, mem_en, mem_we, host_gnt, host_err}, pix_out, mem_addr);
        end
        greset = 1'b0;
    endtask

    task automatic test_timing();
        int n, hs_low, vs_low, de_hi, fs_cnt, line_hs, bad_lines;
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        checks++;
        if (!frame_start) begin
            failures++;
            $display("FAIL timing_fs_wait got frame_start=0 want 1 within %0d cycles", 2 * FRAME);
        end
        hs_low = 0; vs_low = 0; de_hi = 0; fs_cnt = 0; line_hs = 0; bad_lines = 0;
        for (int i = 0; i < FRAME; i++) begin
            hs_low += (hsyn == 1'b0);
            line_hs += (hsyn == 1'b0);
            vs_low += (vsyn == 1'b0);
            de_hi  += (de == 1'b1);
            fs_cnt += (frame_start == 1'b1);
            if (i % HT == HT - 1) begin
                if (line_hs != HS) bad_lines++;
                line_hs = 0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (hs_low != HS * VT || bad_lines != 0) begin
            failures++;
            $display("FAIL timing_hsyn got low=%0d bad_lines=%0d want low=%0d bad_lines=0", hs_low, bad_lines, HS * VT);
        end
        checks++;
        if (vs_low != VS * HT) begin
            failures++;
            $display("FAIL timing_vsyn got low=%0d want %0d", vs_low, VS * HT);
        end
        checks++;
        if (de_hi != DEPTH) begin
            failures++;
            $display("FAIL timing_de got %0d want %0d", de_hi, DEPTH);
        end
        checks++;
        if (fs_cnt != 1 || frame_start !== 1'b1) begin
            failures++;
            $display("FAIL timing_frame got pulses=%0d next_fs=%b want 1 and 1", fs_cnt, frame_start);
        end
    endtask

    task automatic test_pixels();
        int n;
        n = 0;
        while (!de && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        checks++;
        if (de !== 1'b1 || pix_out !== 8'h00) begin
            failures++;
            $display("FAIL pix_first got de=%b pix=%h want 1 00", de, pix_out);
        end
        n = 0;
        while (de && n < 2 * HT) begin @(posedge clk); #1; n++; end
        while (!de && n < 4 * HT) begin @(posedge clk); #1; n++; end
        checks++;
        if (de !== 1'b1 || pix_out !== 8'(HAL)) begin
            failures++;
            $display("FAIL pix_line2 got de=%b pix=%h want 1 %h", de, pix_out, 8'(HAL));
        end
    endtask

    task automatic test_host_active();
        int gh, gv;
        gh = -1; gv = -1;
        wait_pos(12, VAS + 2);
        host_req = 1'b1; host_addr = AW'(50); host_wdata = 8'hA5;
        for (int n = 0; n < 2 * HT; n++) begin
            #1;
            if (host_gnt) begin gh = m_h; gv = m_v; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (gh != HAS + HAL - 1 || gv != VAS + 2) begin
            failures++;
            $display("FAIL host_active_gnt got h=%0d v=%0d want h=%0d v=%0d", gh, gv, HAS + HAL - 1, VAS + 2);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        checks++;
        if (ram[50] !== 8'hA5) begin
            failures++;
            $display("FAIL host_active_ram got %h want a5", ram[50]);
        end
    endtask

    task automatic test_back_to_back();
        int grants;
        grants = 0;
        wait_pos(0, 0);
        for (int k = 0; k < VAS * HT; k++) begin
            host_req = 1'b1; host_addr = AW'(k); host_wdata = 8'(k * 7 + 3);
            #1;
            checks++;
            if (host_gnt !== 1'b1) begin
                failures++;
                $display("FAIL b2b_gnt k=%0d got %b want 1", k, host_gnt);
            end
            grants += int'(host_gnt);
            @(posedge clk); #1;
        end
        host_req = 1'b0;
        checks++;
        if (grants != VAS * HT || ram[0] !== 8'd3 || ram[VAS * HT - 1] !== 8'((VAS * HT - 1) * 7 + 3)) begin
            failures++;
            $display("FAIL b2b_writes got grants=%0d ram0=%h ramN=%h want %0d 03 %h",
                     grants, ram[0], ram[VAS * HT - 1], VAS * HT, 8'((VAS * HT - 1) * 7 + 3));
        end
    endtask

    task automatic test_oob();
        wait_pos(0, 1);
        host_req = 1'b1; host_addr = AW'(DEPTH); host_wdata = 8'hEE;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || host_err !== 1'b0) begin
            failures++;
            $display("FAIL oob_issue got gnt=%b en=%b we=%b err=%b want 1 1 0 0", host_gnt, mem_en, mem_we, host_err);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        checks++;
        if (host_err !== 1'b1 || ram[DEPTH] !== 8'(DEPTH)) begin
            failures++;
            $display("FAIL oob_err got err=%b ram=%h want 1 %h", host_err, ram[DEPTH], 8'(DEPTH));
        end
        @(posedge clk); #1;
        checks++;
        if (host_err !== 1'b0) begin
            failures++;
            $display("FAIL oob_pulse got err=%b want 0", host_err);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        wait_pos(20, 10);
        greset = 1'b1;
        host_req = 1'b1; host_addr = AW'(100); host_wdata = 8'h3C;
        #1;
        checks++;
        if ({hsyn, vsyn, de, frame_start, mem_en, mem_we, host_gnt, host_err} !== 8'h00 ||
            pix_out !== '0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL midrst_zero got %b pix=%h addr=%0d want zeros",
                     {hsyn, vsyn, de, frame_start, mem_en, mem_we, host_gnt, host_err}, pix_out, mem_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        greset = 1'b0;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(100)) begin
            failures++;
            $display("FAIL midrst_rearb got gnt=%b we=%b addr=%0d want 1 1 100", host_gnt, mem_we, mem_addr);
        end
        // h=0 is decoded at the first edge after release; hsyn registers
        // high at the edge that decodes h=HS, i.e. edge number HS+1.
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) host_req = 1'b0;
        end while (!hsyn && n < 2 * HT);
        checks++;
        if (n != HS + 1 || ram[100] !== 8'h3C) begin
            failures++;
            $display("FAIL midrst_hsyn got edges=%0d ram100=%h want %0d 3c", n, ram[100], HS + 1);
        end
        wait_pos(HAS - 1, VAS);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL midrst_first_rd got en=%b we=%b addr=%0d want 1 0 0", mem_en, mem_we, mem_addr);
        end
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog got no finish want finish within 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_pixels();
        test_host_active();
        test_back_to_back();
        test_oob();
        test_mid_reset();
        repeat (2 * FRAME) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vga_fb_scheduler

`default_nettype wire
